// File: rtl/vx_commit_rr.sv
// Commit stage: round-robin arbitration of writeback-capable channels onto one
// registered writeback port, plus a registered per-cycle retired-thread count.
module vx_commit_rr #(
  parameter int                NUM_CH      = 6,
  parameter int                NUM_THREADS = 4,
  parameter int                NUM_WARPS   = 4,
  parameter int                DATA_W      = 32,
  parameter int                RD_W        = 5,
  parameter logic [NUM_CH-1:0] WB_MASK     = 6'b011011,
  localparam int               WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int               CMT_W       = $clog2(NUM_CH*NUM_THREADS+1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CH-1:0]                   cmt_valid,
  output logic [NUM_CH-1:0]                   cmt_ready,
  input  logic [NUM_CH*WID_W-1:0]             cmt_wid,
  input  logic [NUM_CH*NUM_THREADS-1:0]       cmt_tmask,
  input  logic [NUM_CH-1:0]                   cmt_wb,
  input  logic [NUM_CH*RD_W-1:0]              cmt_rd,
  input  logic [NUM_CH*NUM_THREADS*DATA_W-1:0] cmt_data,
  input  logic [NUM_CH-1:0]                   cmt_eop,
  output logic                                wb_valid,
  input  logic                                wb_ready,
  output logic [WID_W-1:0]                    wb_wid,
  output logic [NUM_THREADS-1:0]              wb_tmask,
  output logic [RD_W-1:0]                     wb_rd,
  output logic [NUM_THREADS*DATA_W-1:0]       wb_data,
  output logic                                wb_eop,
  output logic                                csr_valid,
  output logic [CMT_W-1:0]                    csr_commit_size
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0]              ptr;
  logic [PTR_W-1:0]              grant_idx;
  logic [PTR_W-1:0]              ptr_next;
  logic                          grant_vld;
  logic                          can_accept;
  logic                          grant_fire;
  logic                          wb_load;
  logic [NUM_CH-1:0]             req;
  logic [NUM_CH-1:0]             fire;
  logic [NUM_CH-1:0]             retire;
  logic [CMT_W-1:0]              size_c;

  logic [WID_W-1:0]              sel_wid;
  logic [NUM_THREADS-1:0]        sel_tmask;
  logic [RD_W-1:0]               sel_rd;
  logic [NUM_THREADS*DATA_W-1:0] sel_data;
  logic                          sel_eop;
  logic                          sel_wb;

  assign req        = cmt_valid & WB_MASK;
  assign can_accept = !wb_valid || wb_ready;
  assign grant_fire = grant_vld && can_accept && !reset;
  assign wb_load    = grant_fire && sel_wb;
  assign ptr_next   = (grant_idx == PTR_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;

  // Two ascending passes: indices at/after ptr first, then the wrapped low indices.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!grant_vld && req[i] && (PTR_W'(i) >= ptr)) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!grant_vld && req[i] && (PTR_W'(i) < ptr)) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    sel_wid   = '0;
    sel_tmask = '0;
    sel_rd    = '0;
    sel_data  = '0;
    sel_eop   = 1'b0;
    sel_wb    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (PTR_W'(i) == grant_idx) begin
        sel_wid   = cmt_wid[i*WID_W +: WID_W];
        sel_tmask = cmt_tmask[i*NUM_THREADS +: NUM_THREADS];
        sel_rd    = cmt_rd[i*RD_W +: RD_W];
        sel_data  = cmt_data[i*NUM_THREADS*DATA_W +: NUM_THREADS*DATA_W];
        sel_eop   = cmt_eop[i];
        sel_wb    = cmt_wb[i];
      end
    end
  end

  // Non-writeback sinks stay ready even through reset.
  always_comb begin
    cmt_ready = '1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (WB_MASK[i]) begin
        cmt_ready[i] = grant_fire && (grant_idx == PTR_W'(i));
      end
    end
  end

  assign fire   = cmt_valid & cmt_ready;
  assign retire = fire & cmt_eop;

  always_comb begin
    size_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        if (retire[i]) begin
          size_c = size_c + CMT_W'(cmt_tmask[i*NUM_THREADS + t]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid        <= 1'b0;
      wb_wid          <= '0;
      wb_tmask        <= '0;
      wb_rd           <= '0;
      wb_data         <= '0;
      wb_eop          <= 1'b0;
      ptr             <= '0;
      csr_valid       <= 1'b0;
      csr_commit_size <= '0;
    end else begin
      if (wb_load) begin
        wb_valid <= 1'b1;
        wb_wid   <= sel_wid;
        wb_tmask <= sel_tmask;
        wb_rd    <= sel_rd;
        wb_data  <= sel_data;
        wb_eop   <= sel_eop;
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
      if (grant_fire) begin
        ptr <= ptr_next;
      end
      csr_valid       <= |retire;
      csr_commit_size <= size_c;
    end
  end

endmodule

// File: tb/tb_vx_commit_rr.sv
// Randomized bench for vx_commit_rr against a queue-free behavioural model of the
// round-robin commit rules, with a few directed scenarios up front.
module tb_vx_commit_rr;

  localparam int NUM_CH    = 6;
  localparam int NT        = 4;
  localparam int NUM_WARPS = 4;
  localparam int DW        = 32;
  localparam int RD_W      = 5;
  localparam int WID_W     = 2;
  localparam int CMT_W     = 5;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       cmt_valid;
  logic [NUM_CH-1:0]       cmt_ready;
  logic [NUM_CH*WID_W-1:0] cmt_wid;
  logic [NUM_CH*NT-1:0]    cmt_tmask;
  logic [NUM_CH-1:0]       cmt_wb;
  logic [NUM_CH*RD_W-1:0]  cmt_rd;
  logic [NUM_CH*NT*DW-1:0] cmt_data;
  logic [NUM_CH-1:0]       cmt_eop;
  logic                    wb_valid;
  logic                    wb_ready;
  logic [WID_W-1:0]        wb_wid;
  logic [NT-1:0]           wb_tmask;
  logic [RD_W-1:0]         wb_rd;
  logic [NT*DW-1:0]        wb_data;
  logic                    wb_eop;
  logic                    csr_valid;
  logic [CMT_W-1:0]        csr_commit_size;

  vx_commit_rr #(
    .NUM_CH      (NUM_CH),
    .NUM_THREADS (NT),
    .NUM_WARPS   (NUM_WARPS),
    .DATA_W      (DW),
    .RD_W        (RD_W),
    .WB_MASK     (6'b011011)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmt_valid       (cmt_valid),
    .cmt_ready       (cmt_ready),
    .cmt_wid         (cmt_wid),
    .cmt_tmask       (cmt_tmask),
    .cmt_wb          (cmt_wb),
    .cmt_rd          (cmt_rd),
    .cmt_data        (cmt_data),
    .cmt_eop         (cmt_eop),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_wid          (wb_wid),
    .wb_tmask        (wb_tmask),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .wb_eop          (wb_eop),
    .csr_valid       (csr_valid),
    .csr_commit_size (csr_commit_size)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference state
  logic [NUM_CH-1:0] wbm = 6'b011011;
  bit                m_wb_valid;
  logic [WID_W-1:0]  m_wid;
  logic [NT-1:0]     m_tmask;
  logic [RD_W-1:0]   m_rd;
  logic [NT*DW-1:0]  m_data;
  logic              m_eop;
  int                m_ptr;
  bit                m_csr_valid;
  int                m_csr_size;
  int                m_g;
  logic [NUM_CH-1:0] exp_ready;

  task automatic model_ready();
    bit can;
    can = !m_wb_valid || wb_ready;
    m_g = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      int ch;
      ch = (m_ptr + k) % NUM_CH;
      if (m_g < 0 && wbm[ch] && cmt_valid[ch]) m_g = ch;
    end
    exp_ready = '1;
    for (int i = 0; i < NUM_CH; i++)
      if (wbm[i]) exp_ready[i] = (i == m_g) && can && !reset;
  endtask

  task automatic model_update();
    logic [NUM_CH-1:0] f;
    if (reset) begin
      m_wb_valid = 0; m_wid = '0; m_tmask = '0; m_rd = '0; m_data = '0; m_eop = 0;
      m_ptr = 0; m_csr_valid = 0; m_csr_size = 0;
      return;
    end
    f = cmt_valid & exp_ready;
    if (m_g >= 0 && f[m_g]) begin
      if (cmt_wb[m_g]) begin
        m_wb_valid = 1;
        m_wid   = cmt_wid[m_g*WID_W +: WID_W];
        m_tmask = cmt_tmask[m_g*NT +: NT];
        m_rd    = cmt_rd[m_g*RD_W +: RD_W];
        m_data  = cmt_data[m_g*NT*DW +: NT*DW];
        m_eop   = cmt_eop[m_g];
      end else if (wb_ready) m_wb_valid = 0;
      m_ptr = (m_g + 1) % NUM_CH;
    end else if (wb_ready) m_wb_valid = 0;
    m_csr_valid = 0;
    m_csr_size  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (f[i] && cmt_eop[i]) begin
        m_csr_valid = 1;
        m_csr_size += $countones(cmt_tmask[i*NT +: NT]);
      end
    end
  endtask

  task automatic step();
    model_ready();
    #1;
    check("cmt_ready", cmt_ready, exp_ready);
    @(posedge clk);
    model_update();
    #1;
    check("wb_valid", wb_valid, m_wb_valid);
    check("wb_wid", wb_wid, m_wid);
    check("wb_tmask", wb_tmask, m_tmask);
    check("wb_rd", wb_rd, m_rd);
    check("wb_data", wb_data, m_data);
    check("wb_eop", wb_eop, m_eop);
    check("csr_valid", csr_valid, m_csr_valid);
    check("csr_commit_size", csr_commit_size, CMT_W'(m_csr_size));
  endtask

  task automatic clear_inputs();
    cmt_valid = '0; cmt_wid = '0; cmt_tmask = '0; cmt_wb = '0;
    cmt_rd = '0; cmt_data = '0; cmt_eop = '0; wb_ready = 1'b1;
  endtask

  task automatic set_ch(input int ch, input bit wb, input logic [RD_W-1:0] rd,
                        input logic [NT-1:0] tm, input bit eop);
    cmt_valid[ch] = 1'b1;
    cmt_wb[ch]    = wb;
    cmt_rd[ch*RD_W +: RD_W] = rd;
    cmt_tmask[ch*NT +: NT]  = tm;
    cmt_eop[ch]   = eop;
    cmt_wid[ch*WID_W +: WID_W] = WID_W'(ch);
    for (int t = 0; t < NT; t++) cmt_data[(ch*NT+t)*DW +: DW] = $urandom;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Single writeback entry from ch0.
    set_ch(0, 1, 5'd3, 4'b1111, 1);
    step();
    check("t1_wb_valid", wb_valid, 1);
    check("t1_wb_rd", wb_rd, 3);
    check("t1_size", csr_commit_size, 4);

    // Store + GPU sinks fire alongside a granted ch0 (pointer now past ch0, wraps back).
    clear_inputs();
    set_ch(0, 1, 5'd7, 4'b1111, 1);
    set_ch(2, 0, 5'd0, 4'b0011, 1);
    set_ch(5, 0, 5'd0, 4'b1000, 1);
    step();
    check("t4_size", csr_commit_size, 7);

    // Partial-packet beat counts nothing; the closing beat counts its mask.
    clear_inputs();
    set_ch(1, 1, 5'd9, 4'b1111, 0);
    step();
    check("t5_csr_valid0", csr_valid, 0);
    clear_inputs();
    set_ch(1, 1, 5'd9, 4'b0101, 1);
    step();
    check("t5_size", csr_commit_size, 2);

    // Stall with held entry, then reset drops it.
    clear_inputs();
    set_ch(3, 1, 5'd4, 4'b0110, 1);
    wb_ready = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("t3_hold_rd", wb_rd, 9);
    reset = 1'b1;
    step();
    check("t6_wb_valid", wb_valid, 0);
    reset = 1'b0;

    // Continuous requests on all writeback channels: grant order 0,1,3,4.
    clear_inputs();
    for (int c = 0; c < 8; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        if (wbm[ch]) set_ch(ch, 1, RD_W'(ch), 4'b0001, 1);
      step();
    end

    for (int cyc = 0; cyc < 2000; cyc++) begin
      int phase;
      phase = (cyc / 200) % 3;
      reset = ($urandom_range(0, 99) == 0);
      case (phase)
        0: wb_ready = ($urandom_range(0, 9) != 0);
        1: wb_ready = $urandom_range(0, 1);
        default: wb_ready = ($urandom_range(0, 4) == 0);
      endcase
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cmt_valid[ch] = ($urandom_range(0, 9) < 6);
        cmt_wb[ch]    = ($urandom_range(0, 3) != 0);
        cmt_eop[ch]   = ($urandom_range(0, 3) != 0);
      end
      cmt_wid   = NUM_CH*WID_W'($urandom);
      cmt_tmask = NUM_CH*NT'($urandom);
      cmt_rd    = NUM_CH*RD_W'($urandom);
      for (int j = 0; j < NUM_CH*NT; j++) cmt_data[j*DW +: DW] = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
